// File: rtl/divider_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin divider.
// Imported by the arbiter top and the bit-serial datapath.
package divider_arbiter_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_NREQ  = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DIVIDE,
      FINISH
   } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring bit-serial unsigned divider, one quotient bit per cycle.
// done is high in the cycle whose closing edge writes the final bit.
module seq_divider
   import divider_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH:0]   w_diff;

   // partial remainder stays below divisor, so WIDTH+1 bits suffice
   assign w_trial = {r_rem, r_q[WIDTH-1]};
   assign w_diff  = w_trial - {1'b0, r_dvs};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_q   <= '0;
         r_dvs <= '0;
      end else if (start) begin
         r_cnt <= CW'(WIDTH);
         r_rem <= '0;
         r_q   <= dividend;
         r_dvs <= divisor;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CW'(1);
         if (w_diff[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
         end else begin
            r_rem <= w_diff[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   assign quotient  = r_q;
   assign remainder = r_rem;
   assign done      = (r_cnt == CW'(1));

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one bit-serial divider among NREQ requesters.
// Results are registered in FINISH and held until the next completion.
module divider_arbiter
   import divider_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   dividend_flat,
   input  logic [NREQ*WIDTH-1:0]   divisor_flat,
   output logic [WIDTH-1:0]        quotient,
   output logic [WIDTH-1:0]        remainder,
   output logic [$clog2(NREQ)-1:0] result_id,
   output logic [NREQ-1:0]         done_vec,
   output logic                    div0,
   output logic                    busy
);

   localparam int IDW = $clog2(NREQ);

   state_t           r_state;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   w_gnt;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] w_dvd;
   logic [WIDTH-1:0] w_dvs;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;
   logic [NREQ-1:0]  r_done;
   logic             r_zero;
   logic             r_div0;
   logic             r_busy;
   logic             w_start;
   logic             w_div_done;

   // scan downward so the lowest offset from r_ptr wins
   always_comb begin
      w_gnt = r_ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[r_ptr + IDW'(k)]) w_gnt = r_ptr + IDW'(k);
      end
   end

   assign w_dvd   = dividend_flat[r_id*WIDTH +: WIDTH];
   assign w_dvs   = divisor_flat[r_id*WIDTH +: WIDTH];
   assign w_start = (r_state == LOAD) && (w_dvs != '0);

   seq_divider #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (w_start),
      .dividend (w_dvd),
      .divisor  (w_dvs),
      .quotient (w_quo),
      .remainder(w_rem),
      .done     (w_div_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_dvd   <= '0;
         r_zero  <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
         r_div0  <= 1'b0;
         r_done  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_done <= '0;
         unique case (r_state)
            IDLE: begin
               if (req != '0) begin
                  r_id    <= w_gnt;
                  r_ptr   <= w_gnt + IDW'(1);
                  r_busy  <= 1'b1;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_dvd   <= w_dvd;
               r_zero  <= (w_dvs == '0);
               r_state <= (w_dvs == '0) ? FINISH : DIVIDE;
            end
            DIVIDE: begin
               if (w_div_done) r_state <= FINISH;
            end
            FINISH: begin
               r_q          <= r_zero ? '1 : w_quo;
               r_r          <= r_zero ? r_dvd : w_rem;
               r_div0       <= r_zero;
               r_done[r_id] <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign quotient  = r_q;
   assign remainder = r_r;
   assign result_id = r_id;
   assign done_vec  = r_done;
   assign div0      = r_div0;
   assign busy      = r_busy;

endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench for divider_arbiter: directed vectors plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_divider_arbiter;

   localparam int W   = 32;
   localparam int N   = 8;
   localparam int IDW = 3;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] dvd_flat = '0;
   logic [N*W-1:0] dvs_flat = '0;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic [IDW-1:0] result_id;
   logic [N-1:0]   done_vec;
   logic           div0;
   logic           busy;

   divider_arbiter #(
      .WIDTH(W),
      .NREQ (N)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .dividend_flat(dvd_flat),
      .divisor_flat (dvs_flat),
      .quotient     (quotient),
      .remainder    (remainder),
      .result_id    (result_id),
      .done_vec     (done_vec),
      .div0         (div0),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: outputs expected after the next clock edge
   bit           m_busy = 0;
   int           m_t = 0;
   int           m_lat = 0;
   int           m_ptr = 0;
   int           m_id = 0;
   logic [W-1:0] m_a = '0;
   logic [W-1:0] m_b = '0;
   logic [W-1:0] m_q = '0;
   logic [W-1:0] m_r = '0;
   bit           m_div0 = 0;
   logic [N-1:0] m_done = '0;
   bit           auto_drop = 0;
   int           lat;
   int           id;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_ops(int i, logic [W-1:0] a, logic [W-1:0] b);
      dvd_flat[i*W +: W] = a;
      dvs_flat[i*W +: W] = b;
   endtask

   // latency in cycles from grant edge: 3 for /0, W+3 otherwise
   task automatic predict();
      m_done = '0;
      if (reset) begin
         m_busy = 0; m_t = 0; m_ptr = 0; m_id = 0;
         m_q = '0; m_r = '0; m_div0 = 0;
      end else if (m_busy) begin
         if (m_t == 0) begin
            m_a   = dvd_flat[m_id*W +: W];
            m_b   = dvs_flat[m_id*W +: W];
            m_lat = (m_b == 0) ? 3 : W + 3;
         end
         m_t++;
         if (m_t == m_lat - 1) begin
            if (m_b == 0) begin
               m_q = '1; m_r = m_a; m_div0 = 1;
            end else begin
               m_q = m_a / m_b; m_r = m_a % m_b; m_div0 = 0;
            end
            m_done[m_id] = 1'b1;
            m_busy = 0;
         end
      end else if (req != '0) begin
         for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) begin
               m_id = (m_ptr + k) % N;
               break;
            end
         end
         m_ptr  = (m_id + 1) % N;
         m_busy = 1;
         m_t    = 0;
      end
   endtask

   task automatic step();
      predict();
      @(posedge clk);
      @(negedge clk);
      check("done_vec", done_vec, m_done);
      check("busy", busy, m_busy);
      check("result_id", result_id, m_id);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("div0", div0, m_div0);
      if (auto_drop) req = req & ~done_vec;
   endtask

   task automatic wait_done(output int l, output int who);
      bit seen = 0;
      l = 0;
      who = -1;
      for (int c = 0; c < 200 && !seen; c++) begin
         step();
         l++;
         if (done_vec != '0) begin
            seen = 1;
            for (int k = 0; k < N; k++) if (done_vec[k]) who = k;
         end
      end
      if (!seen) check("done_timeout", 1, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_dvs();
      int s = $urandom_range(0, 7);
      if (s == 0) return '0;
      if (s < 3) return W'($urandom_range(1, 15));
      return W'($urandom);
   endfunction

   function automatic logic [W-1:0] rnd_dvd();
      if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 200));
      return W'($urandom);
   endfunction

   task automatic rand_stim();
      bit infl;
      reset = ($urandom_range(0, 1499) == 0);
      for (int i = 0; i < N; i++) begin
         infl = m_busy && (m_id == i);
         if (!req[i] && !infl && $urandom_range(0, 15) == 0) begin
            set_ops(i, rnd_dvd(), rnd_dvs());
            req[i] = 1'b1;
         end else if (infl && m_t >= 1 && $urandom_range(0, 7) == 0) begin
            set_ops(i, rnd_dvd(), rnd_dvs());
         end
         if (infl && $urandom_range(0, 31) == 0) req[i] = 1'b0;
      end
   endtask

   initial begin
      step();
      step();
      reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done_vec, 0);
      check("rst_q", quotient, 0);
      check("rst_id", result_id, 0);

      set_ops(2, 100, 7);
      req[2] = 1'b1;
      wait_done(lat, id);
      req[2] = 1'b0;
      check("s1_lat", lat, 35);
      check("s1_id", id, 2);
      check("s1_q", quotient, 14);
      check("s1_r", remainder, 2);
      check("s1_div0", div0, 0);
      check("s1_rid", result_id, 2);

      do_reset();
      set_ops(0, 50, 5);
      set_ops(3, 77, 10);
      set_ops(5, 1234, 100);
      req[0] = 1'b1; req[3] = 1'b1; req[5] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         wait_done(lat, id);
         check("multi_id", id, (j == 0) ? 0 : (j == 1) ? 3 : 5);
         check("multi_lat", lat, 35);
         if (id >= 0) req[id] = 1'b0;
      end
      check("multi_q5", quotient, 12);
      check("multi_r5", remainder, 34);

      do_reset();
      set_ops(1, 900, 30);
      set_ops(2, 77, 8);
      req[1] = 1'b1; req[2] = 1'b1;
      for (int g = 0; g < 6; g++) begin
         wait_done(lat, id);
         check("fair_id", id, (g % 2 == 0) ? 1 : 2);
      end
      req[1] = 1'b0; req[2] = 1'b0;

      set_ops(4, 32'hDEAD, 0);
      req[4] = 1'b1;
      wait_done(lat, id);
      req[4] = 1'b0;
      check("dz_lat", lat, 3);
      check("dz_id", id, 4);
      check("dz_q", quotient, 32'hFFFF_FFFF);
      check("dz_r", remainder, 32'hDEAD);
      check("dz_div0", div0, 1);

      set_ops(6, 1000, 3);
      req[6] = 1'b1;
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("ab_q", quotient, 0);
      check("ab_r", remainder, 0);
      check("ab_busy", busy, 0);
      check("ab_div0", div0, 0);
      check("ab_done", done_vec, 0);
      wait_done(lat, id);
      req[6] = 1'b0;
      check("ab_lat", lat, 35);
      check("ab_id", id, 6);
      check("ab_q2", quotient, 333);
      check("ab_r2", remainder, 1);

      set_ops(0, 32'hFFFF_FFFF, 1);
      req[0] = 1'b1;
      wait_done(lat, id);
      req[0] = 1'b0;
      check("bnd1_q", quotient, 32'hFFFF_FFFF);
      check("bnd1_r", remainder, 0);
      set_ops(7, 5, 9);
      req[7] = 1'b1;
      wait_done(lat, id);
      req[7] = 1'b0;
      check("bnd2_q", quotient, 0);
      check("bnd2_r", remainder, 5);

      do_reset();
      auto_drop = 1;
      repeat (4000) begin
         rand_stim();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter NREQ, default 8, giving the number of requesters; NREQ is a power of two, 2..16.
REQ-003 Port: clk  in  1  clock; all logic on the rising edge.
REQ-004 Port: reset  in  1  reset, synchronous, active-high.
REQ-005 Port: req  in  NREQ  per-requester level request; held high until that requester's done pulse.
REQ-006 Port: dividend_flat  in  NREQ*WIDTH  unsigned dividend; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 Port: divisor_flat  in  NREQ*WIDTH  unsigned divisor, packed the same way.
REQ-008 Port: quotient  out  WIDTH  quotient of the last completed operation.
REQ-009 Port: remainder  out  WIDTH  remainder of the last completed operation.
REQ-010 Port: result_id  out  log2(NREQ)  requester index of the last completed or in-flight operation.
REQ-011 Port: done_vec  out  NREQ  one-cycle pulse on bit result_id when a result is valid.
REQ-012 Port: div0  out  1  set with done when the divisor was zero; cleared at the next done.
REQ-013 Port: busy  out  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, DIVIDE and FINISH.
REQ-015 IDLE: when req is nonzero, the block SHALL grant one requester round-robin, register result_id and go to LOAD.
REQ-016 Round-robin order SHALL start at index (last granted + 1) mod NREQ and take the first set req bit; after reset the search starts at index 0.
REQ-017 LOAD SHALL capture the granted operands.
REQ-018 In LOAD, a zero divisor SHALL go to FINISH with quotient all-ones, remainder = dividend and div0 = 1.
REQ-019 In LOAD, a nonzero divisor SHALL start the sub-divider and go to DIVIDE.
REQ-020 DIVIDE SHALL produce one quotient bit per cycle, restoring algorithm, MSB first, for exactly WIDTH cycles, then go to FINISH.
REQ-021 FINISH SHALL update quotient and remainder, pulse done_vec[result_id] for one cycle and return to IDLE.
REQ-022 Latency for a nonzero divisor SHALL be WIDTH+3 cycles from the edge that samples req in IDLE to the done pulse.
REQ-023 Latency for a zero divisor SHALL be 3 cycles, measured the same way.
REQ-024 Operand changes after LOAD SHALL NOT affect the in-flight result.
REQ-025 Deasserting req mid-operation SHALL NOT abort it; the done pulse is still issued.
REQ-026 Requests arriving while busy SHALL wait; none is lost while req stays high.
REQ-027 Two requesters held high continuously SHALL be served alternately.
REQ-028 quotient, remainder and div0 SHALL hold their values between done pulses.
REQ-029 Division width rule: quotient and remainder are WIDTH bits; dividend = quotient*divisor + remainder; remainder < divisor.

Reset
REQ-030 Reset SHALL force IDLE and clear the round-robin pointer to 0.
REQ-031 Reset SHALL clear quotient, remainder, result_id, done_vec, div0 and busy to 0.
REQ-032 Reset asserted mid-operation SHALL abort it with no done pulse; a request still held is re-arbitrated after reset releases.

Structure
REQ-033 The FSM state encoding and default WIDTH/NREQ constants SHALL live in a shared package, divider_arbiter_pkg.
REQ-034 The bit-serial datapath SHALL be one sub-module, seq_divider, with ports start, dividend, divisor, quotient, remainder and done.
REQ-035 Arbitration, operand muxing and the FSM SHALL be in divider_arbiter.

Verification (WIDTH=32, NREQ=8)
REQ-036 Single request: req[2]=1, 100/7 -> done_vec[2] 35 cycles later; quotient=14, remainder=2, div0=0, result_id=2.
REQ-037 Simultaneous requests: req[0], req[3] and req[5] rise together -> done pulses in order 0, 3, 5, each 35 cycles apart.
REQ-038 Fairness: req[1] and req[2] held high for 6 grants -> result_id sequence 1, 2, 1, 2, 1, 2.
REQ-039 Divide by zero: req[4], 0xDEAD/0 -> done_vec[4] 3 cycles later; quotient=0xFFFFFFFF, remainder=0xDEAD, div0=1.
REQ-040 Reset mid-DIVIDE on requester 6 -> outputs 0 and no done pulse; with req[6] still high, the next grant is to 6 and the correct result follows.
REQ-041 Boundary operands: 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0; 5/9 -> quotient=0, remainder=5.
